// File: rtl/wf_audio_pkg.sv
// rtl/wf_audio_pkg.sv - shared audio-path defaults and sample types
// Holds I2S frame geometry defaults, derived widths and the stereo pair type.
package wf_audio_pkg;

  localparam int DATA_W      = 16;
  localparam int SCK_LOG2    = 4;
  localparam int SLOT_LOG2   = 5;

  localparam int FRAME_CNT_W = SCK_LOG2 + SLOT_LOG2 + 1;
  localparam int SHIFT_W     = 2 * (2 ** SLOT_LOG2);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/wf_i2s_frame_buf.sv
// rtl/wf_i2s_frame_buf.sv - one-entry stereo holding buffer
// Accepts a pair on s_valid && s_ready and releases it on the take strobe.
module wf_i2s_frame_buf
  import wf_audio_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] left,
  output logic [WIDTH-1:0] right
);

  logic write;

  assign write = s_valid && s_ready;

  // s_ready is kept as a separate register, always the inverse of full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      s_ready <= 1'b1;
      left    <= '0;
      right   <= '0;
    end else begin
      if (write) begin
        left    <= s_left;
        right   <= s_right;
        full    <= 1'b1;
        s_ready <= 1'b0;
      end else if (take) begin
        full    <= 1'b0;
        s_ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wf_i2s_tx.sv
// rtl/wf_i2s_tx.sv - stereo I2S transmitter with clock derivation
// Optional WF_I2S_TX_UNDERRUN_HOLD_EN: replay the last loaded pair on underrun.
module wf_i2s_tx #(
  parameter int DATA_W    = wf_audio_pkg::DATA_W,
  parameter int SCK_LOG2  = wf_audio_pkg::SCK_LOG2,
  parameter int SLOT_LOG2 = wf_audio_pkg::SLOT_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun
);

  localparam int CNT_W     = SCK_LOG2 + SLOT_LOG2 + 1;
  localparam int SLOT_BITS = 2 ** SLOT_LOG2;
  localparam int SH_W      = 2 * SLOT_BITS;
  localparam int PAD_W     = SLOT_BITS - 1 - DATA_W;

  logic [CNT_W-1:0]  frame_cnt;
  logic [SH_W-1:0]   shift_reg;
  logic              fall_evt;
  logic              load_pt;
  logic              full;
  logic [DATA_W-1:0] buf_left;
  logic [DATA_W-1:0] buf_right;

  assign fall_evt = &frame_cnt[SCK_LOG2-1:0];
  assign load_pt  = &frame_cnt;

  wf_i2s_frame_buf #(
    .WIDTH (DATA_W)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_left  (s_left),
    .s_right (s_right),
    .take    (load_pt),
    .full    (full),
    .left    (buf_left),
    .right   (buf_right)
  );

  // Leading zero per slot is the I2S one-bit delay after the lrck edge.
  function automatic logic [SH_W-1:0] frame_word(input logic [DATA_W-1:0] l,
                                                 input logic [DATA_W-1:0] r);
    return {1'b0, l, {PAD_W{1'b0}}, 1'b0, r, {PAD_W{1'b0}}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

`ifdef WF_I2S_TX_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0] last_left;
  logic [DATA_W-1:0] last_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_left  <= '0;
      last_right <= '0;
    end else if (load_pt && full) begin
      last_left  <= buf_left;
      last_right <= buf_right;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (load_pt) begin
      if (full) begin
        shift_reg <= frame_word(buf_left, buf_right);
      end else begin
`ifdef WF_I2S_TX_UNDERRUN_HOLD_EN
        shift_reg <= frame_word(last_left, last_right);
`else
        shift_reg <= '0;
`endif
      end
    end else if (fall_evt) begin
      shift_reg <= {shift_reg[SH_W-2:0], 1'b0};
    end
  end

  // Clocks come straight from counter flops so they cannot glitch.
  assign mclk     = frame_cnt[1];
  assign sck      = frame_cnt[SCK_LOG2-1];
  assign lrck     = frame_cnt[CNT_W-1];
  assign sdata    = shift_reg[SH_W-1];
  assign underrun = load_pt && !full;

endmodule

// File: tb/tb_wf_i2s_tx.sv
// tb/tb_wf_i2s_tx.sv - self-checking bench for wf_i2s_tx
// Frame/slot-level reference model against randomized and directed stimulus.
module tb_wf_i2s_tx;
  import wf_audio_pkg::*;

`ifdef WF_I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int FRAME = 2 ** FRAME_CNT_W;
  localparam int SCKP  = 2 ** SCK_LOG2;
  localparam int SLOT  = 2 ** SLOT_LOG2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_left = '0;
  logic [DATA_W-1:0] s_right = '0;
  logic              mclk, sck, lrck, sdata, underrun;

  int checks = 0;
  int errors = 0;

  int           cyc = 0;
  bit           m_full = 1'b0;
  bit           m_ready = 1'b1;
  bit           acc = 1'b0;
  stereo_pair_t m_buf = '0;
  stereo_pair_t cur = '0;
  stereo_pair_t last = '0;
  stereo_pair_t pend[$];

  wf_i2s_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .mclk     (mclk),
    .sck      (sck),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: cyc is the position since reset, cur is the pair playing this frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_full = 1'b0; m_ready = 1'b1; acc = 1'b0;
      m_buf = '0; cur = '0; last = '0;
    end else begin
      acc = s_valid && m_ready;
      if (cyc % FRAME == FRAME - 1) begin
        if (m_full) begin
          cur = m_buf;
          last = m_buf;
        end else begin
          cur = HOLD ? last : '0;
        end
        m_full = 1'b0;
      end
      if (acc) begin
        m_buf = {s_left, s_right};
        m_full = 1'b1;
      end
      m_ready = !m_full;
      cyc++;
    end
  end

  function automatic logic [5:0] exp_outs();
    int pos, k, b;
    logic [DATA_W-1:0] smp;
    logic sd;
    pos = cyc % FRAME;
    k   = pos / SCKP;
    b   = k % SLOT;
    smp = (k >= SLOT) ? cur.right : cur.left;
    sd  = (b >= 1 && b <= DATA_W) ? smp[DATA_W-b] : 1'b0;
    return {pos % 4 >= 2, pos % SCKP >= SCKP / 2, pos >= FRAME / 2, sd,
            pos == FRAME - 1 && !m_full, m_ready};
  endfunction

  function automatic logic [63:0] word_of(input stereo_pair_t p);
    return {1'b0, p.left, 15'b0, 1'b0, p.right, 15'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (acc && pend.size() > 0) void'(pend.pop_front());
    if (pend.size() > 0) begin
      s_valid = 1'b1;
      {s_left, s_right} = pend[0];
    end else begin
      s_valid = 1'b0;
      s_left  = DATA_W'($urandom);
      s_right = DATA_W'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    pend.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int mr, sr, sh, lr0, lr1;
    logic pm, ps, pl;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mclk, sck, lrck, sdata, underrun, s_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", {mclk, sck, lrck, sdata, underrun, s_ready}, 6'b000001);
    end
    do_reset();
    mr = 0; sr = 0; sh = 0; lr0 = -1; lr1 = -1;
    pm = mclk; ps = sck; pl = lrck;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (mclk && !pm) mr++;
      if (sck && !ps) sr++;
      if (sck) sh++;
      if (lrck && !pl) begin
        if (lr0 < 0) lr0 = cyc; else if (lr1 < 0) lr1 = cyc;
      end
      pm = mclk; ps = sck; pl = lrck;
    end
    checks++;
    if (mr != 2 * FRAME / 4) begin errors++; $display("FAIL mclk_period rises=%0d exp=%0d", mr, 2 * FRAME / 4); end
    checks++;
    if (sr != 2 * FRAME / 16) begin errors++; $display("FAIL sck_period rises=%0d exp=%0d", sr, 2 * FRAME / 16); end
    checks++;
    if (sh != FRAME) begin errors++; $display("FAIL sck_duty high=%0d exp=%0d", sh, FRAME); end
    checks++;
    if (lr1 - lr0 != 1024) begin errors++; $display("FAIL lrck_period got=%0d exp=1024", lr1 - lr0); end
  endtask

  task automatic test_basic_frame();
    logic [63:0] vec;
    int ur;
    do_reset();
    pend.push_back({16'hA5A5, 16'h0F0F});
    vec = '0; ur = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL basic_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (cyc < FRAME && underrun) ur++;
      if (cyc >= FRAME && cyc % SCKP == SCKP / 2) vec[63 - (cyc % FRAME) / SCKP] = sdata;
    end
    checks++;
    if (vec !== 64'h52D28000_07878000) begin errors++; $display("FAIL basic_bits got=%h exp=%h", vec, 64'h52D28000_07878000); end
    checks++;
    if (ur != 0) begin errors++; $display("FAIL basic_underrun got=%0d exp=0", ur); end
  endtask

  task automatic test_underrun();
    logic [63:0] vec, exp_vec;
    int good, bad;
    do_reset();
    pend.push_back({16'h1234, 16'h8001});
    vec = '0; good = 0; bad = 0;
    exp_vec = HOLD ? 64'h091A0000_40008000 : 64'h0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL underrun_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (cyc >= FRAME && underrun) begin
        if (cyc % FRAME == FRAME - 1) good++; else bad++;
      end
      if (cyc >= 3 * FRAME && cyc % SCKP == SCKP / 2) vec[63 - (cyc % FRAME) / SCKP] = sdata;
    end
    checks++;
    if (good != 3 || bad != 0) begin errors++; $display("FAIL underrun_pulses got=%0d/%0d exp=3/0", good, bad); end
    checks++;
    if (vec !== exp_vec) begin errors++; $display("FAIL underrun_data got=%h exp=%h", vec, exp_vec); end
  endtask

  task automatic test_back_to_back();
    stereo_pair_t p1, p2;
    logic [63:0] v1, v2;
    int t2, ur;
    do_reset();
    p1 = stereo_pair_t'($urandom); p2 = stereo_pair_t'($urandom);
    pend.push_back(p1); pend.push_back(p2);
    v1 = '0; v2 = '0; t2 = -1; ur = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL b2b_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (pend.size() == 0 && t2 < 0) t2 = cyc;
      if (cyc < 3 * FRAME - 1 && underrun) ur++;
      if (cyc % SCKP == SCKP / 2) begin
        if (cyc / FRAME == 1) v1[63 - (cyc % FRAME) / SCKP] = sdata;
        if (cyc / FRAME == 2) v2[63 - (cyc % FRAME) / SCKP] = sdata;
      end
    end
    checks++;
    if (t2 != FRAME + 1) begin errors++; $display("FAIL b2b_accept_time got=%0d exp=%0d", t2, FRAME + 1); end
    checks++;
    if (v1 !== word_of(p1)) begin errors++; $display("FAIL b2b_frame1 got=%h exp=%h", v1, word_of(p1)); end
    checks++;
    if (v2 !== word_of(p2)) begin errors++; $display("FAIL b2b_frame2 got=%h exp=%h", v2, word_of(p2)); end
    checks++;
    if (ur != 0) begin errors++; $display("FAIL b2b_underrun got=%0d exp=0", ur); end
  endtask

  task automatic test_load_collision();
    stereo_pair_t p;
    logic [63:0] v1, v2;
    do_reset();
    p = stereo_pair_t'($urandom);
    for (int i = 0; i < FRAME && cyc != FRAME - 2; i++) tick();
    pend.push_back(p);
    tick();
    checks++;
    if (underrun !== 1'b1 || cyc != FRAME - 1) begin
      errors++; $display("FAIL collision_underrun got=%b cyc=%0d exp=1", underrun, cyc);
    end
    v1 = '0; v2 = '0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL collision_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (cyc == FRAME && s_ready !== 1'b0) begin
        errors++; $display("FAIL collision_ready got=%b exp=0", s_ready);
      end
      if (cyc % SCKP == SCKP / 2) begin
        if (cyc / FRAME == 1) v1[63 - (cyc % FRAME) / SCKP] = sdata;
        if (cyc / FRAME == 2) v2[63 - (cyc % FRAME) / SCKP] = sdata;
      end
    end
    checks++;
    if (v1 !== 64'h0) begin errors++; $display("FAIL collision_frame1 got=%h exp=0", v1); end
    checks++;
    if (v2 !== word_of(p)) begin errors++; $display("FAIL collision_frame2 got=%h exp=%h", v2, word_of(p)); end
  endtask

  task automatic test_reset_mid();
    int ur;
    do_reset();
    pend.push_back(stereo_pair_t'($urandom));
    for (int i = 0; i < 2 * FRAME && cyc != FRAME + 300; i++) begin
      tick();
      if (cyc == FRAME + 200) pend.push_back(stereo_pair_t'($urandom));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mclk, sck, lrck, sdata, underrun, s_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL midreset_async got=%b exp=%b", {mclk, sck, lrck, sdata, underrun, s_ready}, 6'b000001);
    end
    do_reset();
    ur = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL midreset_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (underrun) ur = ur + ((cyc == FRAME - 1) ? 1 : 100);
    end
    checks++;
    if (ur != 1) begin errors++; $display("FAIL midreset_restart got=%0d exp=1", ur); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 6 * FRAME; i++) begin
      tick();
      checks++;
      if ({mclk, sck, lrck, sdata, underrun, s_ready} !== exp_outs()) begin
        errors++;
        $display("FAIL random_run cyc=%0d got=%b exp=%b", cyc, {mclk, sck, lrck, sdata, underrun, s_ready}, exp_outs());
      end
      if (pend.size() == 0 && $urandom_range(0, 599) == 0) begin
        pend.push_back(stereo_pair_t'($urandom));
        if ($urandom_range(0, 1) == 1) pend.push_back(stereo_pair_t'($urandom));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_underrun();
    test_back_to_back();
    test_load_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
